// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the IF/ID hazard controller: the FSM state type and
// the register/NOP constants.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_WAIT_IMEM  = 2'd1,
    ST_FLUSH_PEND = 2'd2
  } state_t;

  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam logic [31:0] NOP_INSN = 32'h0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W      = 16,
  parameter int REG_ADDR_W = 5
);

  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_branch_taken;
  logic                  imem_ready;

  logic                  imem_req;
  logic                  pc_write;
  logic                  if_id_write;
  logic                  if_id_flush;
  logic                  id_ex_bubble;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      wait_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           ex_mem_read, ex_rd, ex_branch_taken, imem_ready,
    input  imem_req, pc_write, if_id_write, if_id_flush, id_ex_bubble,
           stall_cnt, wait_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           ex_mem_read, ex_rd, ex_branch_taken, imem_ready,
    output imem_req, pc_write, if_id_write, if_id_flush, id_ex_bubble,
           stall_cnt, wait_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use detector: a load in EX writing a register the ID
// instruction reads. Writes to x0 never create a dependency.
module load_use_detect
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  uses_rs1,
  input  logic                  uses_rs2,
  input  logic                  mem_read,
  input  logic [REG_ADDR_W-1:0] rd,
  output logic                  load_use
);

  logic rd_live;
  logic hit_rs1;
  logic hit_rs2;

  assign rd_live  = mem_read && (rd != REG_ADDR_W'(REG_ZERO));
  assign hit_rs1  = uses_rs1 && (rs1 == rd);
  assign hit_rs2  = uses_rs2 && (rs2 == rd);
  assign load_use = rd_live && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// IF/ID and PC sequencer: resolves taken branches, load-use stalls and imem
// wait states each cycle, and keeps saturating counts of each event.
//
// state         | meaning
// --------------+-----------------------------------------------------------
// ST_RUN        | fetch issued, previous fetch returned normally
// ST_WAIT_IMEM  | fetch outstanding, PC held until imem_ready
// ST_FLUSH_PEND | stale fetch outstanding after a redirect; its word is dropped
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int REG_ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  pipe_hazard_ctrl_if.slave        bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t state;
  state_t state_nxt;

  logic load_use;
  logic branch;
  logic ready;

  logic imem_req;
  logic pc_write;
  logic if_id_write;
  logic if_id_flush;
  logic id_ex_bubble;

  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] flush_cnt;

  assign branch = bus.ex_branch_taken;
  assign ready  = bus.imem_ready;

  load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_load_use_detect (
    .rs1      (bus.id_rs1),
    .rs2      (bus.id_rs2),
    .uses_rs1 (bus.id_uses_rs1),
    .uses_rs2 (bus.id_uses_rs2),
    .mem_read (bus.ex_mem_read),
    .rd       (bus.ex_rd),
    .load_use (load_use)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_RUN;
    else       state <= state_nxt;
  end

  // RUN and WAIT_IMEM decode identically; they differ only in how they were entered.
  // Unused encodings fall into the default arm and behave as RUN.
  always_comb begin
    state_nxt    = ST_RUN;
    imem_req     = 1'b0;
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (reset) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else begin
      case (state)
        ST_FLUSH_PEND: begin
          if_id_flush = 1'b1;
          if (branch) begin
            pc_write     = 1'b1;
            id_ex_bubble = 1'b1;
          end
          state_nxt = ready ? ST_RUN : ST_FLUSH_PEND;
        end
        default: begin
          imem_req = 1'b1;
          if (branch) begin
            pc_write     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            state_nxt    = ready ? ST_RUN : ST_FLUSH_PEND;
          end else if (load_use) begin
            // PC holds too, so the fetched word is simply refetched next cycle.
            id_ex_bubble = 1'b1;
            state_nxt    = ready ? ST_RUN : ST_WAIT_IMEM;
          end else if (!ready) begin
            if_id_flush = 1'b1;
            state_nxt   = ST_WAIT_IMEM;
          end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      wait_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      if (load_use && !branch && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_ONE;
      if (imem_req && !ready && (wait_cnt != '1))   wait_cnt  <= wait_cnt + CNT_ONE;
      if (branch && (flush_cnt != '1))              flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

  assign bus.imem_req     = imem_req;
  assign bus.pc_write     = pc_write;
  assign bus.if_id_write  = if_id_write;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_bubble = id_ex_bubble;
  assign bus.stall_cnt    = stall_cnt;
  assign bus.wait_cnt     = wait_cnt;
  assign bus.flush_cnt    = flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic, checked
// against an event-level model (stale-fetch flag and integer counters).
module tb_pipe_hazard_ctrl;

  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic clk;
  logic reset;

  int n_checks = 0;
  int n_fail   = 0;

  // model: a redirect left an older fetch in flight whose word must be dropped
  bit m_stale  = 1'b0;
  int m_stall  = 0;
  int m_wait   = 0;
  int m_flush  = 0;

  pipe_hazard_ctrl_if #(.CNT_W(CW), .REG_ADDR_W(5)) bus ();

  pipe_hazard_ctrl #(.CNT_W(CW), .REG_ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // One clock: drive inputs, check combinational outputs, clock, check counters.
  task automatic cyc(input bit rst, input bit br, input bit rdy, input bit mr,
                     input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input bit u1, input bit u2);
    bit lu, e_req, e_pcw, e_ifw, e_fl, e_bub;
    reset               = rst;
    bus.ex_branch_taken = br;
    bus.imem_ready      = rdy;
    bus.ex_mem_read     = mr;
    bus.ex_rd           = rd;
    bus.id_rs1          = rs1;
    bus.id_rs2          = rs2;
    bus.id_uses_rs1     = u1;
    bus.id_uses_rs2     = u2;

    lu = mr && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    if (rst) begin
      e_req = 0; e_pcw = 0; e_ifw = 0; e_fl = 1; e_bub = 1;
    end else if (m_stale) begin
      e_req = 0; e_pcw = br; e_ifw = 0; e_fl = 1; e_bub = br;
    end else begin
      e_req = 1;
      if (br)        begin e_pcw = 1; e_ifw = 0; e_fl = 1; e_bub = 1; end
      else if (lu)   begin e_pcw = 0; e_ifw = 0; e_fl = 0; e_bub = 1; end
      else if (!rdy) begin e_pcw = 0; e_ifw = 0; e_fl = 1; e_bub = 0; end
      else           begin e_pcw = 1; e_ifw = 1; e_fl = 0; e_bub = 0; end
    end

    #3;
    check("imem_req",     32'(bus.imem_req),     32'(e_req));
    check("pc_write",     32'(bus.pc_write),     32'(e_pcw));
    check("if_id_write",  32'(bus.if_id_write),  32'(e_ifw));
    check("if_id_flush",  32'(bus.if_id_flush),  32'(e_fl));
    check("id_ex_bubble", 32'(bus.id_ex_bubble), 32'(e_bub));

    if (rst) begin
      m_stale = 0; m_stall = 0; m_wait = 0; m_flush = 0;
    end else begin
      if (lu && !br)     m_stall = sat_inc(m_stall);
      if (e_req && !rdy) m_wait  = sat_inc(m_wait);
      if (br)            m_flush = sat_inc(m_flush);
      m_stale = m_stale ? !rdy : (br && !rdy);
    end

    @(posedge clk);
    #1;
    check("stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
    check("wait_cnt",  32'(bus.wait_cnt),  32'(m_wait));
    check("flush_cnt", 32'(bus.flush_cnt), 32'(m_flush));
  endtask

  task automatic idle(input bit rst, input bit rdy);
    cyc(rst, 0, rdy, 0, 5'd0, 5'd0, 5'd0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.ex_branch_taken = 0; bus.imem_ready = 1; bus.ex_mem_read = 0;
    bus.ex_rd = 0; bus.id_rs1 = 0; bus.id_rs2 = 0;
    bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0;
    @(posedge clk);
    #1;

    // reset state
    idle(1, 1);
    idle(1, 1);
    check("reset_stall", 32'(bus.stall_cnt), 32'd0);

    // 1: load-use on rs1 stalls
    cyc(0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 1, 0);
    check("t1_stall_cnt", 32'(bus.stall_cnt), 32'd1);

    // 2: x0 destination and unused rs2 never stall
    cyc(0, 0, 1, 1, 5'd0, 5'd0, 5'd0, 1, 0);
    cyc(0, 0, 1, 1, 5'd7, 5'd1, 5'd7, 1, 0);
    check("t2_stall_cnt", 32'(bus.stall_cnt), 32'd1);
    cyc(0, 0, 1, 1, 5'd7, 5'd1, 5'd7, 1, 1);

    // 3: branch beats load-use
    idle(1, 1);
    cyc(0, 1, 1, 1, 5'd5, 5'd5, 5'd0, 1, 0);
    check("t3_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    check("t3_flush_cnt", 32'(bus.flush_cnt), 32'd1);

    // 4: three wait cycles then the word arrives
    idle(1, 1);
    for (int i = 0; i < 3; i++) idle(0, 0);
    idle(0, 1);
    check("t4_wait_cnt", 32'(bus.wait_cnt), 32'd3);

    // 5: branch while waiting, stale word dropped
    idle(1, 1);
    idle(0, 0);
    cyc(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    #3;
    check("t5_flush_pend_req", 32'(bus.imem_req), 32'd0);
    #1;
    cyc(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(0, 1);
    idle(0, 1);

    // 6: wait_cnt saturates, then reset out of FLUSH_PEND
    idle(1, 1);
    for (int i = 0; i < CMAX - 1; i++) idle(0, 0);
    check("t6_wait_pre", 32'(bus.wait_cnt), 32'(CMAX - 1));
    for (int i = 0; i < 4; i++) idle(0, 0);
    check("t6_wait_sat", 32'(bus.wait_cnt), 32'(CMAX));
    cyc(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(1, 0);
    check("t6_reset_wait", 32'(bus.wait_cnt), 32'd0);
    idle(0, 1);

    // random traffic over a narrow register range to provoke hazards
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 59) == 0),
          ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 2) != 0),
          $urandom_range(0, 1) == 1,
          5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)),
          $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
